// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair: TX (host->machine) and RX (machine->host) FIFO pair for one
// PIO state machine. Two DEPTH-entry banks; either FIFO can borrow the other's
// bank for a 2*DEPTH capacity. Sticky over/underflow flags with write-1-to-clear.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   join_tx, join_rx      lend RX bank to TX / TX bank to RX (both = neither)
//   tx_push, tx_din       host write into TX
//   tx_pull               machine pops TX head
//   tx_dout/full/empty/level  TX show-ahead head word and status
//   rx_push, rx_din       machine write into RX
//   rx_pull               host pops RX head
//   rx_dout/full/empty/level  RX show-ahead head word and status
//   dbg_clr               write-1-to-clear {rx_under, rx_over, tx_under, tx_over}
//   dbg                   sticky flags {rx_under, rx_over, tx_under, tx_over}
module pio_fifo_pair #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LEVEL_W = $clog2(2*DEPTH)+1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               join_tx,
   input  logic               join_rx,
   input  logic               tx_push,
   input  logic [WIDTH-1:0]   tx_din,
   input  logic               tx_pull,
   output logic [WIDTH-1:0]   tx_dout,
   output logic               tx_full,
   output logic               tx_empty,
   output logic [LEVEL_W-1:0] tx_level,
   input  logic               rx_push,
   input  logic [WIDTH-1:0]   rx_din,
   input  logic               rx_pull,
   output logic [WIDTH-1:0]   rx_dout,
   output logic               rx_full,
   output logic               rx_empty,
   output logic [LEVEL_W-1:0] rx_level,
   input  logic [3:0]         dbg_clr,
   output logic [3:0]         dbg
);

   localparam int unsigned PTR_W   = $clog2(2*DEPTH);
   localparam int unsigned ENTRIES = 2*DEPTH;

   localparam logic [LEVEL_W-1:0] CAP_NORM  = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] CAP_JOIN  = LEVEL_W'(ENTRIES);
   localparam logic [PTR_W-1:0]   BANK_FLIP = PTR_W'(DEPTH);

   // Unified storage: entries [0,DEPTH) are bank0, [DEPTH,2*DEPTH) are bank1.
   logic [WIDTH-1:0] mem [ENTRIES];

   // Effective mode {rx_joined, tx_joined}; both-set collapses to 00.
   logic [1:0] mode_d, mode_q;
   logic       flush;

   logic [LEVEL_W-1:0] tx_cap, rx_cap;
   logic [PTR_W-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PTR_W-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [LEVEL_W-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
   logic               tx_push_ok, tx_pull_ok, rx_push_ok, rx_pull_ok;
   logic [3:0]         dbg_q, dbg_d, dbg_set;

   // Advance a pointer modulo the current capacity.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                 input logic [LEVEL_W-1:0] cap);
      logic [LEVEL_W-1:0] nxt;
      nxt = LEVEL_W'(p) + LEVEL_W'(1);
      return (nxt == cap) ? '0 : nxt[PTR_W-1:0];
   endfunction

   assign mode_d = {join_rx & ~join_tx, join_tx & ~join_rx};
   assign flush  = (mode_d != mode_q);

   // Capacity follows the registered mode so it always matches pointer layout.
   always_comb begin
      tx_cap = CAP_NORM;
      rx_cap = CAP_NORM;
      if (mode_q[0]) begin
         tx_cap = CAP_JOIN;
         rx_cap = '0;
      end else if (mode_q[1]) begin
         tx_cap = '0;
         rx_cap = CAP_JOIN;
      end
   end

   assign tx_full  = (tx_lvl_q == tx_cap);
   assign tx_empty = (tx_lvl_q == '0);
   assign rx_full  = (rx_lvl_q == rx_cap);
   assign rx_empty = (rx_lvl_q == '0);
   assign tx_level = tx_lvl_q;
   assign rx_level = rx_lvl_q;
   assign dbg      = dbg_q;

   // TX starts in bank0; RX starts in bank1 (address MSB flipped).
   assign tx_dout = tx_empty ? '0 : mem[tx_rd_q];
   assign rx_dout = rx_empty ? '0 : mem[rx_rd_q ^ BANK_FLIP];

   // Accepts; everything is discarded during a mode-change flush.
   assign tx_pull_ok = tx_pull & ~tx_empty & ~flush;
   assign tx_push_ok = tx_push & (~tx_full | tx_pull_ok) & ~flush;
   assign rx_pull_ok = rx_pull & ~rx_empty & ~flush;
   assign rx_push_ok = rx_push & (~rx_full | rx_pull_ok) & ~flush;

   assign dbg_set = {rx_pull & rx_empty & ~flush,
                     rx_push & ~rx_push_ok & ~flush,
                     tx_pull & tx_empty & ~flush,
                     tx_push & ~tx_push_ok & ~flush};

   // Next-state for pointers, levels and flags.
   always_comb begin
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      tx_lvl_d = tx_lvl_q;
      rx_lvl_d = rx_lvl_q;
      dbg_d    = (dbg_q & ~dbg_clr) | dbg_set;

      if (flush) begin
         tx_wr_d  = '0;
         tx_rd_d  = '0;
         rx_wr_d  = '0;
         rx_rd_d  = '0;
         tx_lvl_d = '0;
         rx_lvl_d = '0;
      end else begin
         if (tx_push_ok) tx_wr_d = ptr_inc(tx_wr_q, tx_cap);
         if (tx_pull_ok) tx_rd_d = ptr_inc(tx_rd_q, tx_cap);
         if (rx_push_ok) rx_wr_d = ptr_inc(rx_wr_q, rx_cap);
         if (rx_pull_ok) rx_rd_d = ptr_inc(rx_rd_q, rx_cap);
         if (tx_push_ok && !tx_pull_ok) tx_lvl_d = tx_lvl_q + LEVEL_W'(1);
         if (!tx_push_ok && tx_pull_ok) tx_lvl_d = tx_lvl_q - LEVEL_W'(1);
         if (rx_push_ok && !rx_pull_ok) rx_lvl_d = rx_lvl_q + LEVEL_W'(1);
         if (!rx_push_ok && rx_pull_ok) rx_lvl_d = rx_lvl_q - LEVEL_W'(1);
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= '0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_lvl_q <= '0;
         rx_lvl_q <= '0;
         dbg_q    <= '0;
      end else begin
         mode_q   <= mode_d;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         tx_lvl_q <= tx_lvl_d;
         rx_lvl_q <= rx_lvl_d;
         dbg_q    <= dbg_d;
      end
   end

   // Storage writes; banks never overlap between TX and RX in any mode.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (tx_push_ok) mem[tx_wr_q] <= tx_din;
         if (rx_push_ok) mem[rx_wr_q ^ BANK_FLIP] <= rx_din;
      end
   end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed self-checking bench for pio_fifo_pair (WIDTH=32, DEPTH=4).
module tb_pio_fifo_pair;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned LEVEL_W = $clog2(2*DEPTH)+1;

   logic               clk = 1'b0;
   logic               reset;
   logic               join_tx, join_rx;
   logic               tx_push, tx_pull, rx_push, rx_pull;
   logic [WIDTH-1:0]   tx_din, rx_din, tx_dout, rx_dout;
   logic               tx_full, tx_empty, rx_full, rx_empty;
   logic [LEVEL_W-1:0] tx_level, rx_level;
   logic [3:0]         dbg_clr, dbg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .join_tx(join_tx), .join_rx(join_rx),
      .tx_push(tx_push), .tx_din(tx_din), .tx_pull(tx_pull), .tx_dout(tx_dout),
      .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
      .rx_push(rx_push), .rx_din(rx_din), .rx_pull(rx_pull), .rx_dout(rx_dout),
      .rx_full(rx_full), .rx_empty(rx_empty), .rx_level(rx_level),
      .dbg_clr(dbg_clr), .dbg(dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tx_push = 0; tx_pull = 0; rx_push = 0; rx_pull = 0; dbg_clr = '0;
   endtask

   initial begin
      reset = 1; join_tx = 0; join_rx = 0;
      tx_din = '0; rx_din = '0;
      idle();
      step(); step();
      check("rst_tx_level", 32'(tx_level), 0);
      check("rst_tx_empty", 32'(tx_empty), 1);
      check("rst_tx_full",  32'(tx_full),  0);
      check("rst_tx_dout",  tx_dout, 0);
      check("rst_rx_empty", 32'(rx_empty), 1);
      check("rst_rx_full",  32'(rx_full),  0);
      check("rst_rx_dout",  rx_dout, 0);
      check("rst_dbg",      32'(dbg), 0);
      reset = 0;

      // Fill TX with A0..A3.
      for (int i = 0; i < 4; i++) begin
         tx_push = 1; tx_din = 32'hA0 + 32'(i);
         step();
         check("tx_fill_level", 32'(tx_level), 32'(i + 1));
         check("tx_fill_full",  32'(tx_full), (i == 3) ? 1 : 0);
      end

      // Overflow drops data and sets tx_over; then clear it.
      tx_din = 32'hBB;
      step();
      check("tx_over_dbg",   32'(dbg), 32'h1);
      check("tx_over_level", 32'(tx_level), 4);
      tx_push = 0; dbg_clr = 4'b0001;
      step();
      check("tx_over_clr", 32'(dbg), 0);
      dbg_clr = '0;

      // Drain TX in order.
      for (int i = 0; i < 4; i++) begin
         check("tx_drain_dout", tx_dout, 32'hA0 + 32'(i));
         tx_pull = 1;
         step();
      end
      tx_pull = 0;
      check("tx_drain_empty", 32'(tx_empty), 1);
      check("tx_drain_dout0", tx_dout, 0);
      check("tx_drain_dbg",   32'(dbg), 0);

      // Joined TX: 8 entries across both banks; RX has no capacity.
      join_tx = 1;
      step();
      check("jtx_rx_full",  32'(rx_full), 1);
      check("jtx_rx_empty", 32'(rx_empty), 1);
      for (int i = 0; i < 8; i++) begin
         tx_push = 1; tx_din = 32'h10 + 32'(i);
         step();
         check("jtx_fill_full", 32'(tx_full), (i == 7) ? 1 : 0);
      end
      tx_push = 0;
      check("jtx_level", 32'(tx_level), 8);
      for (int i = 0; i < 8; i++) begin
         check("jtx_drain_dout", tx_dout, 32'h10 + 32'(i));
         tx_pull = 1;
         step();
      end
      check("jtx_empty", 32'(tx_empty), 1);
      check("jtx_dbg_clean", 32'(dbg), 0);
      step();
      tx_pull = 0;
      check("jtx_under", 32'(dbg), 32'h2);
      join_tx = 0; dbg_clr = 4'hF;
      step();
      check("jtx_unjoin_dbg", 32'(dbg), 0);
      dbg_clr = '0;

      // RX holds 2 words, tx_under set; then join_rx flushes without touching dbg.
      rx_push = 1; rx_din = 32'h21; tx_pull = 1;
      step();
      rx_din = 32'h22; tx_pull = 0;
      step();
      check("rx2_level", 32'(rx_level), 2);
      check("rx2_dbg",   32'(dbg), 32'h2);
      join_rx = 1; rx_din = 32'h99;   // push in flush cycle is discarded
      step();
      rx_push = 0;
      check("jrx_flush_rx_level", 32'(rx_level), 0);
      check("jrx_flush_tx_level", 32'(tx_level), 0);
      check("jrx_flush_dbg",      32'(dbg), 32'h2);
      for (int i = 0; i < 8; i++) begin
         rx_push = 1; rx_din = 32'h30 + 32'(i);
         step();
      end
      rx_push = 0;
      check("jrx_level",   32'(rx_level), 8);
      check("jrx_rx_full", 32'(rx_full), 1);
      check("jrx_tx_full", 32'(tx_full), 1);
      for (int i = 0; i < 8; i++) begin
         check("jrx_drain_dout", rx_dout, 32'h30 + 32'(i));
         rx_pull = 1;
         step();
      end
      rx_pull = 0;
      check("jrx_empty", 32'(rx_empty), 1);
      join_rx = 0; dbg_clr = 4'hF;
      step();
      dbg_clr = '0;
      check("unjoin_dbg", 32'(dbg), 0);

      // RX full: simultaneous push and pull.
      for (int i = 0; i < 4; i++) begin
         rx_push = 1; rx_din = 32'h40 + 32'(i);
         step();
      end
      check("rxfull_full", 32'(rx_full), 1);
      rx_din = 32'h44; rx_pull = 1;
      step();
      rx_push = 0; rx_pull = 0;
      check("rxpp_level", 32'(rx_level), 4);
      check("rxpp_dbg",   32'(dbg), 0);
      for (int i = 0; i < 4; i++) begin
         check("rxpp_drain_dout", rx_dout, 32'h41 + 32'(i));
         rx_pull = 1;
         step();
      end
      rx_pull = 0;
      check("rxpp_empty", 32'(rx_empty), 1);

      // Empty RX: push+pull accepts push, flags underflow.
      rx_push = 1; rx_pull = 1; rx_din = 32'h55;
      step();
      rx_push = 0; rx_pull = 0;
      check("rxe_dbg",   32'(dbg), 32'h8);
      check("rxe_level", 32'(rx_level), 1);
      check("rxe_dout",  rx_dout, 32'h55);

      // Reset mid-burst wins over everything.
      tx_push = 1; tx_din = 32'h66; rx_push = 1; rx_din = 32'h77; reset = 1;
      step();
      check("mid_rst_tx_level", 32'(tx_level), 0);
      check("mid_rst_rx_level", 32'(rx_level), 0);
      check("mid_rst_dbg",      32'(dbg), 0);
      check("mid_rst_rx_dout",  rx_dout, 0);
      idle(); reset = 0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
